// File: rtl/mem_wb_buffer.sv
// D-cache write-back buffer: circular FIFO of evicted lines drained to unified memory by a 3-state FSM.
// Define MEM_WB_FWD_EN to forward buffered lines to fills instead of stalling on an address match.
module mem_wb_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [13:0] wb_addr,
  input  logic [63:0] wb_data,
  output logic        wb_full,
  input  logic        rd_req,
  input  logic [13:0] rd_addr,
  output logic        rd_hit,
  output logic [63:0] rd_data,
  output logic        rd_stall,
  output logic [13:0] u_addr,
  output logic [63:0] u_wdata,
  output logic        u_we,
  input  logic        u_rdy,
  output logic        empty,
  output logic [3:0]  count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t        state, state_next;
  logic [13:0]   addr_mem [DEPTH];
  logic [63:0]   data_mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [3:0]    cnt;
  logic          push, pop, match;

  // Status comes only from registered occupancy, so a same-edge pop never frees a slot early.
  assign wb_full = (cnt == 4'(DEPTH));
  assign empty   = (cnt == 4'd0);
  assign count   = cnt;
  assign push    = wb_we && !wb_full && !rst;
  assign pop     = (state == WRITE) && u_rdy;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= 4'd0;
      state <= IDLE;
    end else begin
      state <= state_next;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      cnt <= cnt + 4'(push) - 4'(pop);
    end
  end

  // NOTE: line storage is not reset; validity is defined purely by head/count, which are.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= wb_addr;
      data_mem[tail] <= wb_data;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (!empty) state_next = WRITE;
      WRITE:   if (u_rdy)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Head stays put for the whole WRITE phase, so address and data are stable until the pop.
  assign u_we    = (state == WRITE);
  assign u_addr  = empty ? 14'd0 : addr_mem[head];
  assign u_wdata = empty ? 64'd0 : data_mem[head];

`ifdef MEM_WB_FWD_EN
  logic [63:0] match_data;
`endif

  // Scan oldest to youngest so the last match seen is the youngest copy of the line.
  always_comb begin
    match = 1'b0;
`ifdef MEM_WB_FWD_EN
    match_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if (4'(k) < cnt && addr_mem[head + PW'(k)] == rd_addr) begin
        match = 1'b1;
`ifdef MEM_WB_FWD_EN
        match_data = data_mem[head + PW'(k)];
`endif
      end
    end
  end

`ifdef MEM_WB_FWD_EN
  assign rd_hit   = rd_req && match;
  assign rd_data  = rd_hit ? match_data : 64'd0;
  assign rd_stall = rd_req && (state == WRITE) && !match;
`else
  // Without forwarding a fill of a buffered line must wait until that line reaches memory.
  assign rd_hit   = 1'b0;
  assign rd_data  = 64'd0;
  assign rd_stall = rd_req && ((state == WRITE) || match);
`endif

endmodule

// File: tb/tb_mem_wb_buffer.sv
// Self-checking bench for mem_wb_buffer: directed scenarios plus random traffic against a queue model.
module tb_mem_wb_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, wb_we, wb_full, rd_req, rd_hit, rd_stall, u_we, u_rdy, empty;
  logic [13:0] wb_addr, rd_addr, u_addr;
  logic [63:0] wb_data, rd_data, u_wdata;
  logic [3:0]  count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_full(wb_full), .rd_req(rd_req), .rd_addr(rd_addr), .rd_hit(rd_hit),
    .rd_data(rd_data), .rd_stall(rd_stall), .u_addr(u_addr), .u_wdata(u_wdata),
    .u_we(u_we), .u_rdy(u_rdy), .empty(empty), .count(count)
  );

  typedef struct {
    logic [13:0] a;
    logic [63:0] d;
  } ent_t;

  ent_t        q[$];        // buffered lines, oldest first
  bit          m_wr;        // memory write strobe expected this cycle
  bit          m_turn;      // turnaround cycle after a completed write
  logic [13:0] drained[$];  // addresses seen leaving on u_we && u_rdy

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    bit          hz;
    logic [63:0] yd;
    hz = 1'b0;
    yd = '0;
    foreach (q[i]) if (q[i].a == rd_addr) begin hz = 1'b1; yd = q[i].d; end
    hz = hz && rd_req;
    check("count",   64'(count),   64'(q.size()));
    check("empty",   64'(empty),   64'(q.size() == 0));
    check("wb_full", 64'(wb_full), 64'(q.size() == DEPTH));
    check("u_we",    64'(u_we),    64'(m_wr));
    check("u_addr",  64'(u_addr),  (q.size() != 0) ? 64'(q[0].a) : 64'd0);
    check("u_wdata", u_wdata,      (q.size() != 0) ? q[0].d : 64'd0);
`ifdef MEM_WB_FWD_EN
    check("rd_hit",   64'(rd_hit),   64'(hz));
    check("rd_data",  rd_data,       hz ? yd : 64'd0);
    check("rd_stall", 64'(rd_stall), 64'(rd_req && m_wr && !hz));
`else
    check("rd_hit",   64'(rd_hit),   64'd0);
    check("rd_data",  rd_data,       64'd0);
    check("rd_stall", 64'(rd_stall), 64'(rd_req && (m_wr || hz)));
`endif
  endtask

  task automatic drive(input bit r, input bit we, input logic [13:0] wa, input logic [63:0] wd,
                       input bit rdy, input bit rq, input logic [13:0] ra);
    @(negedge clk);
    rst = r; wb_we = we; wb_addr = wa; wb_data = wd; u_rdy = rdy; rd_req = rq; rd_addr = ra;
    #1;
    check_model();
    if (u_we && u_rdy && !rst) drained.push_back(u_addr);
  endtask

  task automatic tick();
    bit push, pop;
    int n;
    @(posedge clk);
    n = q.size();
    if (rst) begin
      q.delete();
      m_wr = 1'b0;
      m_turn = 1'b0;
    end else begin
      pop  = m_wr && u_rdy;
      push = wb_we && (n < DEPTH);
      if (m_wr) begin
        if (u_rdy) begin m_wr = 1'b0; m_turn = 1'b1; end
      end else if (m_turn) m_turn = 1'b0;
      else if (n > 0) m_wr = 1'b1;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back('{wb_addr, wb_data});
    end
  endtask

  task automatic step(input bit r, input bit we, input logic [13:0] wa, input logic [63:0] wd,
                      input bit rdy, input bit rq, input logic [13:0] ra);
    drive(r, we, wa, wd, rdy, rq, ra);
    tick();
  endtask

  task automatic wait_write(input string tag);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (u_we) break;
      step(0, 0, 14'd0, 64'd0, 0, 0, 14'd0);
    end
    #1;
    check(tag, 64'(u_we), 64'd1);
  endtask

  initial begin
    logic [63:0] d38, dx, dy;
    rst = 1'b1; wb_we = 1'b0; wb_addr = '0; wb_data = '0; u_rdy = 1'b0; rd_req = 1'b0; rd_addr = '0;
    m_wr = 1'b0; m_turn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_full",  64'(wb_full),  64'd0);
    check("rst_empty",    64'(empty),    64'd1);
    check("rst_count",    64'(count),    64'd0);
    check("rst_u_we",     64'(u_we),     64'd0);
    check("rst_u_addr",   64'(u_addr),   64'd0);
    check("rst_u_wdata",  u_wdata,       64'd0);
    check("rst_rd_hit",   64'(rd_hit),   64'd0);
    check("rst_rd_stall", 64'(rd_stall), 64'd0);
    step(1, 0, 14'd0, 64'd0, 0, 0, 14'd0);

    // Single line drains with u_rdy tied high.
    step(0, 1, 14'h0123, 64'hAAAA_BBBB_CCCC_DDDD, 1, 0, 14'd0);
    step(0, 0, 14'd0, 64'd0, 1, 0, 14'd0);
    #1;
    check("single_u_we",    64'(u_we),   64'd1);
    check("single_u_addr",  64'(u_addr), 64'h0123);
    check("single_u_wdata", u_wdata,     64'hAAAA_BBBB_CCCC_DDDD);
    step(0, 0, 14'd0, 64'd0, 1, 0, 14'd0);
    step(0, 0, 14'd0, 64'd0, 1, 0, 14'd0);
    #1;
    check("single_empty", 64'(empty), 64'd1);

    // Overfill while memory is busy; a pop and a blocked enqueue share one edge.
    drained.delete();
    for (int i = 0; i < 5; i++) step(0, 1, 14'h100 + 14'(i), {$urandom, $urandom}, 0, 0, 14'd0);
    #1;
    check("fill_count", 64'(count),   64'd4);
    check("fill_full",  64'(wb_full), 64'd1);
    step(0, 1, 14'h1FF, 64'h1, 1, 0, 14'd0);
    #1;
    check("full_pop_count", 64'(count), 64'd3);
    repeat (15) step(0, 0, 14'd0, 64'd0, 1, 0, 14'd0);
    check("fill_drain_n", 64'(drained.size()), 64'd4);
    for (int i = 0; i < drained.size() && i < 4; i++)
      check("fill_drain_order", 64'(drained[i]), 64'h100 + 64'(i));

    // Memory stalls for 10 cycles mid-write.
    d38 = {$urandom, $urandom};
    step(0, 1, 14'h02AA, d38, 0, 0, 14'd0);
    wait_write("stall_reach_write");
    drained.delete();
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 14'd0, 64'd0, 0, 0, 14'd0);
      #1;
      check("stall_u_we",    64'(u_we),   64'd1);
      check("stall_u_addr",  64'(u_addr), 64'h02AA);
      check("stall_u_wdata", u_wdata,     d38);
    end
    step(0, 0, 14'd0, 64'd0, 1, 0, 14'd0);
    #1;
    check("stall_count", 64'(count), 64'd0);
    check("stall_pops",  64'(drained.size()), 64'd1);

    // Duplicate address: fill request against two buffered copies.
    dx = {$urandom, $urandom};
    dy = ~dx;
    step(0, 1, 14'h0040, dx, 0, 0, 14'd0);
    step(0, 1, 14'h0040, dy, 0, 0, 14'd0);
    drive(0, 0, 14'd0, 64'd0, 0, 1, 14'h0040);
`ifdef MEM_WB_FWD_EN
    check("dup_rd_hit",   64'(rd_hit),   64'd1);
    check("dup_rd_data",  rd_data,       dy);
    check("dup_rd_stall", 64'(rd_stall), 64'd0);
`else
    check("dup_rd_hit",   64'(rd_hit),   64'd0);
    check("dup_rd_stall", 64'(rd_stall), 64'd1);
`endif
    tick();
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 14'd0, 64'd0, 1, 1, 14'h0040);
      #1;
      if (empty) break;
    end
    check("dup_drained", 64'(empty), 64'd1);
    drive(0, 0, 14'd0, 64'd0, 1, 1, 14'h0040);
    check("dup_stall_clear", 64'(rd_stall), 64'd0);
    tick();

    // Count held by simultaneous push/pop, then reset abandons a write.
    for (int i = 0; i < 3; i++) step(0, 1, 14'h300 + 14'(i), {$urandom, $urandom}, 0, 0, 14'd0);
    #1;
    check("three_count", 64'(count), 64'd3);
    step(0, 1, 14'h0303, {$urandom, $urandom}, 1, 0, 14'd0);
    #1;
    check("pushpop_count", 64'(count), 64'd3);
    wait_write("rst_reach_write");
    step(1, 1, 14'h3FF, 64'h5, 1, 0, 14'd0);
    #1;
    check("midrst_u_we",  64'(u_we),  64'd0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_empty", 64'(empty), 64'd1);

    // Random traffic over a small address set to exercise matches and wrap.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), 14'(16 * $urandom_range(0, 5)),
           {$urandom, $urandom}, $urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
           14'(16 * $urandom_range(0, 5)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
